// File: rtl/march_bist_ctrl_pkg.sv
// Shared FSM encoding and March C- element table for the BIST controller.
package march_bist_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [2:0] M0 = 3'd0;
   localparam logic [2:0] M1 = 3'd1;
   localparam logic [2:0] M2 = 3'd2;
   localparam logic [2:0] M3 = 3'd3;
   localparam logic [2:0] M4 = 3'd4;
   localparam logic [2:0] M5 = 3'd5;

   // pol = 0 selects the background, pol = 1 its complement
   typedef struct packed {
      logic down;
      logic two;
      logic wr0;
      logic pol0;
      logic wr1;
      logic pol1;
   } elem_t;

   function automatic elem_t elem_info(input logic [2:0] e);
      elem_t t;
      case (e)
         M0:      t = '{down: 1'b0, two: 1'b0, wr0: 1'b1, pol0: 1'b0, wr1: 1'b0, pol1: 1'b0};
         M1:      t = '{down: 1'b0, two: 1'b1, wr0: 1'b0, pol0: 1'b0, wr1: 1'b1, pol1: 1'b1};
         M2:      t = '{down: 1'b0, two: 1'b1, wr0: 1'b0, pol0: 1'b1, wr1: 1'b1, pol1: 1'b0};
         M3:      t = '{down: 1'b1, two: 1'b1, wr0: 1'b0, pol0: 1'b0, wr1: 1'b1, pol1: 1'b1};
         M4:      t = '{down: 1'b1, two: 1'b1, wr0: 1'b0, pol0: 1'b1, wr1: 1'b1, pol1: 1'b0};
         default: t = '{down: 1'b0, two: 1'b0, wr0: 1'b0, pol0: 1'b0, wr1: 1'b0, pol1: 1'b0};
      endcase
      return t;
   endfunction

endpackage

// File: rtl/march_cmp_pipe.sv
// Two-stage expected-data pipeline aligned to the 2-cycle memory read
// latency, plus mismatch counting and first-failure capture.
module march_cmp_pipe #(
   parameter int DW = 8,
   parameter int AW = 4,
   parameter int CW = 16
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clr,
   input  logic          i_vld,
   input  logic [DW-1:0] i_exp,
   input  logic [AW-1:0] i_addr,
   input  logic [2:0]    i_elem,
   input  logic          i_bg,
   input  logic [DW-1:0] i_rdata,
   output logic          o_fail,
   output logic [CW-1:0] o_count,
   output logic [AW-1:0] o_addr,
   output logic [2:0]    o_elem,
   output logic          o_bg,
   output logic [DW-1:0] o_syn
);

   logic          r_v0, r_v1;
   logic [DW-1:0] r_e0, r_e1;
   logic [AW-1:0] r_a0, r_a1;
   logic [2:0]    r_m0, r_m1;
   logic          r_b0, r_b1;
   logic [DW-1:0] w_syn;
   logic          w_mis;

   assign w_syn = i_rdata ^ r_e1;
   assign w_mis = r_v1 && (w_syn != '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_v0 <= 1'b0; r_e0 <= '0; r_a0 <= '0; r_m0 <= '0; r_b0 <= 1'b0;
         r_v1 <= 1'b0; r_e1 <= '0; r_a1 <= '0; r_m1 <= '0; r_b1 <= 1'b0;
         o_fail  <= 1'b0;
         o_count <= '0;
         o_addr  <= '0;
         o_elem  <= '0;
         o_bg    <= 1'b0;
         o_syn   <= '0;
      end else begin
         r_v0 <= i_vld; r_e0 <= i_exp; r_a0 <= i_addr;
         r_m0 <= i_elem; r_b0 <= i_bg;
         r_v1 <= r_v0; r_e1 <= r_e0; r_a1 <= r_a0;
         r_m1 <= r_m0; r_b1 <= r_b0;
         if (i_clr) begin
            o_fail  <= 1'b0;
            o_count <= '0;
            o_addr  <= '0;
            o_elem  <= '0;
            o_bg    <= 1'b0;
            o_syn   <= '0;
         end else if (w_mis) begin
            o_fail <= 1'b1;
            if (o_count != '1) o_count <= o_count + CW'(1);
            if (!o_fail) begin
               o_addr <= r_a1;
               o_elem <= r_m1;
               o_bg   <= r_b1;
               o_syn  <= w_syn;
            end
         end
      end
   end

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- MBIST controller: op/address generator with write-data lead,
// run FSM, and the compare pipeline instance.
module march_bist_ctrl
   import march_bist_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int CAPACITY   = 16,
   parameter logic [DATA_WIDTH-1:0] BG_PATTERN = 8'h55,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [CNT_WIDTH-1:0]  fail_count,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]            fail_elem,
   output logic                  fail_bg,
   output logic [DATA_WIDTH-1:0] fail_syndrome,
   output logic                  mem_write_read,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(CAPACITY - 1);

   logic [1:0]            r_state;
   logic                  r_dcnt;
   logic                  r_pass;
   logic [2:0]            r_elem;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic                  r_slot;
   logic                  r_end;

   logic                  w_n_pass;
   logic [2:0]            w_n_elem;
   logic [ADDR_WIDTH-1:0] w_n_idx;
   logic                  w_n_slot;
   logic                  w_n_end;
   elem_t                 w_ct;
   elem_t                 w_nt;
   logic                  w_cur_we;
   logic [ADDR_WIDTH-1:0] w_cur_addr;
   logic [DATA_WIDTH-1:0] w_cur_data;
   logic [DATA_WIDTH-1:0] w_lead;
   logic                  w_go;
   logic                  w_issue;

   function automatic logic [DATA_WIDTH-1:0] bg_data(
      input logic p, input logic pol);
      logic [DATA_WIDTH-1:0] b;
      b = p ? BG_PATTERN : '0;
      return pol ? ~b : b;
   endfunction

   assign w_ct       = elem_info(r_elem);
   assign w_nt       = elem_info(w_n_elem);
   assign w_cur_we   = r_slot ? w_ct.wr1 : w_ct.wr0;
   assign w_cur_addr = w_ct.down ? LAST - r_idx : r_idx;
   assign w_cur_data = bg_data(r_pass, r_slot ? w_ct.pol1 : w_ct.pol0);

   // memory latches wdata a cycle early, so present the next op's data now
   always_comb begin
      w_lead = '0;
      if (!w_n_end && (w_n_slot ? w_nt.wr1 : w_nt.wr0))
         w_lead = bg_data(w_n_pass, w_n_slot ? w_nt.pol1 : w_nt.pol0);
   end

   always_comb begin
      w_n_pass = r_pass;
      w_n_elem = r_elem;
      w_n_idx  = r_idx;
      w_n_slot = 1'b0;
      w_n_end  = 1'b0;
      if (!r_slot && w_ct.two) begin
         w_n_slot = 1'b1;
      end else if (r_idx != LAST) begin
         w_n_idx = r_idx + ADDR_WIDTH'(1);
      end else begin
         w_n_idx = '0;
         if (r_elem != M5) begin
            w_n_elem = r_elem + 3'd1;
         end else begin
            w_n_elem = M0;
            if (r_pass) w_n_end = 1'b1;
            else        w_n_pass = 1'b1;
         end
      end
   end

   assign w_go    = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
   assign w_issue = w_go || ((r_state == ST_RUN) && !r_end);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_dcnt         <= 1'b0;
         r_pass         <= 1'b0;
         r_elem         <= M0;
         r_idx          <= '0;
         r_slot         <= 1'b0;
         r_end          <= 1'b0;
         mem_write_read <= 1'b0;
         mem_address    <= '0;
         mem_wdata      <= '0;
      end else begin
         mem_write_read <= 1'b0;
         mem_address    <= '0;
         mem_wdata      <= '0;
         if (w_issue) begin
            mem_write_read <= w_cur_we;
            mem_address    <= w_cur_addr;
            mem_wdata      <= w_lead;
            r_pass         <= w_n_pass;
            r_elem         <= w_n_elem;
            r_idx          <= w_n_idx;
            r_slot         <= w_n_slot;
            r_end          <= w_n_end;
         end
         case (r_state)
            ST_IDLE, ST_DONE: if (start) r_state <= ST_RUN;
            ST_RUN: begin
               if (r_end) begin
                  r_state <= ST_DRAIN;
                  r_dcnt  <= 1'b0;
                  r_pass  <= 1'b0;
                  r_end   <= 1'b0;
               end
            end
            ST_DRAIN: begin
               r_dcnt <= 1'b1;
               if (r_dcnt) r_state <= ST_DONE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign done = (r_state == ST_DONE);

   march_cmp_pipe #(
      .DW (DATA_WIDTH),
      .AW (ADDR_WIDTH),
      .CW (CNT_WIDTH)
   ) u_cmp (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_clr   (w_go),
      .i_vld   (w_issue && !w_cur_we),
      .i_exp   (w_cur_data),
      .i_addr  (w_cur_addr),
      .i_elem  (r_elem),
      .i_bg    (r_pass),
      .i_rdata (mem_rdata),
      .o_fail  (fail),
      .o_count (fail_count),
      .o_addr  (fail_addr),
      .o_elem  (fail_elem),
      .o_bg    (fail_bg),
      .o_syn   (fail_syndrome)
   );

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Directed bench for march_bist_ctrl with a behavioural fault-injectable memory.
module tb_march_bist_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy, done, fail, fail_bg, mem_write_read;
   logic [15:0] fail_count;
   logic [3:0]  fail_addr, mem_address;
   logic [2:0]  fail_elem;
   logic [7:0]  fail_syndrome, mem_wdata, mem_rdata;

   march_bist_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .busy           (busy),
      .done           (done),
      .fail           (fail),
      .fail_count     (fail_count),
      .fail_addr      (fail_addr),
      .fail_elem      (fail_elem),
      .fail_bg        (fail_bg),
      .fail_syndrome  (fail_syndrome),
      .mem_write_read (mem_write_read),
      .mem_address    (mem_address),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata)
   );

   always #5 clk = ~clk;

   // memory: wdata registered one cycle ahead, 2-cycle read latency
   logic [7:0] mem [0:15];
   logic [7:0] wd_q = 8'h00;
   int         rd5 = 0;
   int         fmode = 0;

   initial begin
      mem_rdata = 8'h00;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
   end

   always @(posedge clk) begin
      wd_q <= mem_wdata;
      if (start && !busy) rd5 <= 0;
      if (mem_write_read) begin
         mem[mem_address] <= (fmode == 2 && mem_address == 4'd0) ?
                             (wd_q & 8'hFE) : wd_q;
      end else begin
         mem_rdata <= mem[mem_address] ^
                      ((fmode == 1 && mem_address == 4'd5 && rd5 == 7) ?
                       8'h40 : 8'h00);
         if (mem_address == 4'd5 && !(start && !busy)) rd5 <= rd5 + 1;
      end
   end

   int nvec = 0;
   int nmis = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [12:0] exp_tr [0:319];
   logic [12:0] got_tr [0:319];
   logic [17:0] snap0;

   // reference March C- stream: {we, addr, lead wdata (writes only)}
   initial begin
      int k;
      logic [7:0] bg;
      int nops [6];
      bit dn [6];
      int kind [6][2];
      nops = '{1, 2, 2, 2, 2, 1};
      dn   = '{0, 0, 0, 1, 1, 0};
      // 0 r bg, 1 r nb, 2 w bg, 3 w nb
      kind = '{'{2, 0}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, 0}};
      k = 0;
      for (int p = 0; p < 2; p++) begin
         bg = (p == 1) ? 8'h55 : 8'h00;
         for (int e = 0; e < 6; e++)
            for (int j = 0; j < 16; j++)
               for (int s = 0; s < nops[e]; s++) begin
                  logic [3:0] a;
                  logic       we;
                  logic [7:0] d;
                  a  = dn[e] ? 4'(15 - j) : 4'(j);
                  we = kind[e][s] >= 2;
                  d  = kind[e][s][0] ? ~bg : bg;
                  exp_tr[k] = {we, a, we ? d : 8'h00};
                  k++;
               end
      end
   end

   task automatic run_bist(input int restart_at, output int nbusy);
      logic [7:0] prev;
      prev  = mem_wdata;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nbusy = 0;
      for (int k = 0; k < 1000; k++) begin
         if (done) break;
         if (k == 0) snap0 = {fail, fail_count, done};
         nbusy += int'(busy);
         if (k < 320)
            got_tr[k] = {mem_write_read, mem_address,
                         mem_write_read ? prev : 8'h00};
         prev  = mem_wdata;
         start = (k == restart_at);
         @(negedge clk);
      end
      start = 1'b0;
      chk("run_done", 64'(done), 64'd1);
   endtask

   function automatic logic [47:0] all_out();
      return {busy, done, fail, fail_count, fail_addr, fail_elem, fail_bg,
              fail_syndrome, mem_write_read, mem_address, mem_wdata};
   endfunction

   initial begin
      int nb;
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", 64'(all_out()), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // fault-free run with full trace check
      run_bist(-1, nb);
      chk("busy_cycles", 64'(nb), 64'd322);
      chk("clean_fail", 64'(fail), 64'd0);
      chk("clean_count", 64'(fail_count), 64'd0);
      chk("op0", 64'(got_tr[0]), {51'd0, 1'b1, 4'd0, 8'h00});
      chk("op16", 64'(got_tr[16][12:8]), {59'd0, 1'b0, 4'd0});
      chk("lead_AA", 64'(got_tr[177]), {51'd0, 1'b1, 4'd0, 8'hAA});
      chk("lead_55", 64'(got_tr[160]), {51'd0, 1'b1, 4'd0, 8'h55});
      for (int k = 0; k < 320; k++) chk("trace", 64'(got_tr[k]), 64'(exp_tr[k]));
      chk("done_idle_mem", 64'({mem_write_read, mem_address, mem_wdata}), 64'd0);

      // bit 6 flip on the M3 pass-1 read of address 5
      fmode = 1;
      run_bist(-1, nb);
      chk("flip_fail", 64'(fail), 64'd1);
      chk("flip_addr", 64'(fail_addr), 64'd5);
      chk("flip_elem", 64'(fail_elem), 64'd3);
      chk("flip_bg", 64'(fail_bg), 64'd1);
      chk("flip_syn", 64'(fail_syndrome), 64'h40);
      chk("flip_count", 64'(fail_count), 64'd1);

      // stuck-at-0 bit 0 at address 0: fails M2,M4 pass0 and M1,M3,M5 pass1
      fmode = 2;
      run_bist(-1, nb);
      chk("sa0_start_clr", 64'(snap0), 64'd0);
      chk("sa0_fail", 64'(fail), 64'd1);
      chk("sa0_elem", 64'(fail_elem), 64'd2);
      chk("sa0_addr", 64'(fail_addr), 64'd0);
      chk("sa0_bg", 64'(fail_bg), 64'd0);
      chk("sa0_syn", 64'(fail_syndrome), 64'h01);
      chk("sa0_count", 64'(fail_count), 64'd5);

      // rerun after a failing run, with a stray start mid-run
      fmode = 0;
      run_bist(50, nb);
      chk("rerun_clr", 64'(snap0), 64'd0);
      chk("rerun_busy", 64'(nb), 64'd322);
      chk("rerun_fail", 64'(fail), 64'd0);
      chk("rerun_count", 64'(fail_count), 64'd0);
      chk("rerun_syn", 64'(fail_syndrome), 64'd0);

      // reset 100 cycles into a run
      fmode = 2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_outs", 64'(all_out()), 64'd0);
      rst = 1'b0;
      fmode = 0;
      @(negedge clk);
      chk("post_rst_idle", 64'(all_out()), 64'd0);
      run_bist(-1, nb);
      chk("post_rst_busy", 64'(nb), 64'd322);
      chk("post_rst_fail", 64'(fail), 64'd0);
      chk("post_rst_count", 64'(fail_count), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
